act_zeroexpand: RTL and testbench

//  Streaming zero-skip decoder: rebuilds one dense GROUP_SIZE activation vector from a

---
 rtl/act_zeroexpand_if.sv | 27 ++
 rtl/act_zeroexpand.sv | 106 ++++++++++
 tb/tb_act_zeroexpand.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/act_zeroexpand_if.sv
// Stream bundle for the zero-skip decoder: mask stream, packed non-zero stream, dense output.
// The master side feeds mask/data and consumes the dense group; the slave side is the decoder.
interface act_zeroexpand_if #(
    parameter int GROUP_SIZE = 32,
    parameter int NZ_LANES   = 8,
    parameter int DATA_W     = 8
);
    logic                           znz_valid;
    logic                           znz_ready;
    logic [GROUP_SIZE-1:0]          znz_din;
    logic                           nz_valid;
    logic                           nz_ready;
    logic [NZ_LANES*DATA_W-1:0]     nz_din;
    logic                           act_valid;
    logic                           act_ready;
    logic [GROUP_SIZE*DATA_W-1:0]   act_dout;

    modport master (
        output znz_valid, znz_din, nz_valid, nz_din, act_ready,
        input  znz_ready, nz_ready, act_valid, act_dout
    );

    modport slave (
        input  znz_valid, znz_din, nz_valid, nz_din, act_ready,
        output znz_ready, nz_ready, act_valid, act_dout
    );
endinterface

// File: rtl/act_zeroexpand.sv
// Zero-skip decoder: scatters packed non-zero values back into their dense lanes using
// the group's znz mask. One group in flight, handshakes decoded from state only.
module act_zeroexpand #(
    parameter int GROUP_SIZE = 32,
    parameter int NZ_LANES   = 8,
    parameter int DATA_W     = 8
) (
    input  logic           clk,
    input  logic           rst,
    act_zeroexpand_if.slave bus
);
    localparam int CNT_W = $clog2(GROUP_SIZE + 1);
    localparam int IDX_W = (NZ_LANES > 1) ? $clog2(NZ_LANES) : 1;

    localparam logic [1:0] ST_MASK = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    logic [1:0]                   state;
    logic [GROUP_SIZE-1:0]        mask_q;
    logic [CNT_W-1:0]             need_q;
    logic [CNT_W-1:0]             consumed_q;
    logic [GROUP_SIZE*DATA_W-1:0] buf_q;

    logic [CNT_W-1:0]             mask_pop;
    logic [GROUP_SIZE-1:0]        lane_hit;
    logic [IDX_W-1:0]             lane_sel [GROUP_SIZE];
    logic [CNT_W:0]               consumed_sum;
    logic [CNT_W-1:0]             consumed_next;

    assign bus.znz_ready = (state == ST_MASK) && !rst;
    assign bus.nz_ready  = (state == ST_DATA) && !rst;
    assign bus.act_valid = (state == ST_OUT);
    assign bus.act_dout  = buf_q;

    always_comb begin
        mask_pop = '0;
        for (int i = 0; i < GROUP_SIZE; i++) begin
            mask_pop = mask_pop + CNT_W'(bus.znz_din[i]);
        end
    end

    // Rank of lane p is the count of non-zero lanes below it; a lane is filled by the
    // current beat when its rank falls inside the window starting at consumed_q.
    always_comb begin
        logic [CNT_W-1:0] run;
        logic [CNT_W-1:0] offset;
        run      = '0;
        offset   = '0;
        lane_hit = '0;
        for (int p = 0; p < GROUP_SIZE; p++) begin
            offset      = run - consumed_q;
            lane_hit[p] = mask_q[p] && (run >= consumed_q) && (offset < CNT_W'(NZ_LANES));
            lane_sel[p] = offset[IDX_W-1:0];
            run         = run + CNT_W'(mask_q[p]);
        end
    end

    always_comb begin
        consumed_sum  = {1'b0, consumed_q} + (CNT_W+1)'(NZ_LANES);
        consumed_next = (consumed_sum >= (CNT_W+1)'(GROUP_SIZE)) ? CNT_W'(GROUP_SIZE)
                                                                  : consumed_sum[CNT_W-1:0];
    end

    // Buffer is cleared on every mask handshake so masked-off lanes never carry stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_MASK;
            mask_q     <= '0;
            need_q     <= '0;
            consumed_q <= '0;
            buf_q      <= '0;
        end else begin
            case (state)
                ST_MASK: begin
                    if (bus.znz_valid) begin
                        mask_q     <= bus.znz_din;
                        need_q     <= mask_pop;
                        consumed_q <= '0;
                        buf_q      <= '0;
                        state      <= (mask_pop == '0) ? ST_OUT : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bus.nz_valid) begin
                        for (int p = 0; p < GROUP_SIZE; p++) begin
                            if (lane_hit[p]) begin
                                buf_q[p*DATA_W +: DATA_W] <= bus.nz_din[lane_sel[p]*DATA_W +: DATA_W];
                            end
                        end
                        consumed_q <= consumed_next;
                        if (consumed_next >= need_q) begin
                            state <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (bus.act_ready) begin
                        state <= ST_MASK;
                    end
                end
                default: state <= ST_MASK;
            endcase
        end
    end
endmodule

// File: tb/tb_act_zeroexpand.sv
// Bench for act_zeroexpand: directed corner groups plus random masks/values, checked
// against a queue-based scatter model of the dense group.
module tb_act_zeroexpand;
    localparam int GROUP_SIZE = 32;
    localparam int NZ_LANES   = 8;
    localparam int DATA_W     = 8;
    localparam int BUS_W      = GROUP_SIZE * DATA_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checkCount = 0;
    int   errorCount = 0;
    logic [DATA_W-1:0] vals [GROUP_SIZE];

    act_zeroexpand_if #(.GROUP_SIZE(GROUP_SIZE), .NZ_LANES(NZ_LANES), .DATA_W(DATA_W)) bus ();

    act_zeroexpand #(.GROUP_SIZE(GROUP_SIZE), .NZ_LANES(NZ_LANES), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Dense group = the first need values handed out in order to the set mask bits.
    function automatic logic [BUS_W-1:0] modelDense(input logic [GROUP_SIZE-1:0] mask, input int need);
        logic [DATA_W-1:0] q [$];
        logic [BUS_W-1:0]  d;
        d = '0;
        for (int k = 0; k < need; k++) q.push_back(vals[k]);
        for (int p = 0; p < GROUP_SIZE; p++) begin
            if (mask[p]) d[p*DATA_W +: DATA_W] = q.pop_front();
        end
        return d;
    endfunction

    function automatic logic [BUS_W-1:0] flags();
        return BUS_W'({bus.act_valid, bus.znz_ready, bus.nz_ready});
    endfunction

    task automatic sendMask(input logic [GROUP_SIZE-1:0] mask);
        int cyc = 0;
        bus.znz_valid = 1'b1;
        bus.znz_din   = mask;
        while (!bus.znz_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.znz_ready) checkOutput("mask_timeout", BUS_W'(0), BUS_W'(1));
        @(negedge clk);
        bus.znz_valid = 1'b0;
        bus.znz_din   = '0;
    endtask

    task automatic sendBeat(input logic [NZ_LANES*DATA_W-1:0] beat);
        int cyc = 0;
        bus.nz_valid = 1'b1;
        bus.nz_din   = beat;
        while (!bus.nz_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.nz_ready) checkOutput("beat_timeout", BUS_W'(0), BUS_W'(1));
        @(negedge clk);
        bus.nz_valid = 1'b0;
        bus.nz_din   = '0;
    endtask

    task automatic applyStimulus(input logic [GROUP_SIZE-1:0] mask, input int hold, input int maxGap);
        int need  = $countones(mask);
        int beats = (need + NZ_LANES - 1) / NZ_LANES;
        logic [BUS_W-1:0] expDense;
        logic [NZ_LANES*DATA_W-1:0] beat;
        expDense = modelDense(mask, need);
        sendMask(mask);
        checkOutput("valid_after_mask", BUS_W'(bus.act_valid), BUS_W'(need == 0));
        for (int b = 0; b < beats; b++) begin
            repeat ($urandom_range(0, maxGap)) @(negedge clk);
            for (int l = 0; l < NZ_LANES; l++) begin
                beat[l*DATA_W +: DATA_W] = (b*NZ_LANES + l < need) ? vals[b*NZ_LANES + l]
                                                                    : DATA_W'($urandom);
            end
            sendBeat(beat);
            checkOutput("valid_after_beat", BUS_W'(bus.act_valid), BUS_W'(b == beats - 1));
        end
        for (int h = 0; h <= hold; h++) begin
            checkOutput("out_flags", flags(), BUS_W'(3'b100));
            checkOutput("act_dout", bus.act_dout, expDense);
            if (h < hold) @(negedge clk);
        end
        bus.act_ready = 1'b1;
        @(negedge clk);
        bus.act_ready = 1'b0;
        checkOutput("after_act_hs", flags(), BUS_W'(3'b010));
    endtask

    task automatic randomVals();
        for (int i = 0; i < GROUP_SIZE; i++) vals[i] = DATA_W'($urandom);
    endtask

    initial begin
        logic [GROUP_SIZE-1:0] mask;
        bus.znz_valid = 1'b0;
        bus.znz_din   = '0;
        bus.nz_valid  = 1'b0;
        bus.nz_din    = '0;
        bus.act_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_flags", flags(), BUS_W'(3'b000));
        checkOutput("reset_dout", bus.act_dout, BUS_W'(0));
        rst = 1'b0;
        #1;
        checkOutput("post_reset_flags", flags(), BUS_W'(3'b010));
        @(negedge clk);

        randomVals();
        applyStimulus(32'h0000_0000, 0, 0);

        randomVals();
        vals[0] = 8'h11;
        vals[1] = 8'h22;
        applyStimulus(32'h8000_0001, 0, 0);

        for (int i = 0; i < GROUP_SIZE; i++) vals[i] = DATA_W'(i + 1);
        applyStimulus(32'hFFFF_FFFF, 0, 0);

        for (int i = 0; i < GROUP_SIZE; i++) vals[i] = DATA_W'(i + 1);
        applyStimulus(32'h0000_01FF, 0, 1);

        randomVals();
        applyStimulus(32'hFFFF_FFFF, 5, 0);
        randomVals();
        applyStimulus(32'h0F0F_00F0, 0, 0);

        // Abandon a full group halfway through with an asynchronous reset.
        sendMask(32'hFFFF_FFFF);
        sendBeat(64'h0102_0304_0506_0708);
        sendBeat(64'h1112_1314_1516_1718);
        rst = 1'b1;
        #1;
        checkOutput("midreset_flags", flags(), BUS_W'(3'b000));
        checkOutput("midreset_dout", bus.act_dout, BUS_W'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midreset_release", flags(), BUS_W'(3'b010));
        @(negedge clk);
        for (int i = 0; i < GROUP_SIZE; i++) vals[i] = DATA_W'(i + 5);
        applyStimulus(32'h0000_000F, 0, 0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: mask = $urandom;
                1: mask = $urandom & $urandom;
                2: mask = $urandom | $urandom;
                default: mask = (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
            endcase
            randomVals();
            applyStimulus(mask, $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule
